tt_um_jleugeri_token_aggregator: RTL and testbench

Upstream feeder for tt_um_jleugeri_event_processor_core. It collects token_start/token_end pulses from N_SOURCES source processors and weights each pulse by a per-source signed good weight and a per-source signed bad weight. It outputs per-cycle signed new_good_tokens/new_bad_tokens deltas for one target core. When the summed delta exceeds the output range, the excess is carried in residual registers and drained over later cycles, so no tokens are lost.

---
 rtl/tt_um_jleugeri_tokens_pkg.sv | 39 +++
 rtl/tt_um_jleugeri_token_aggregator_if.sv | 43 ++++
 rtl/tt_um_jleugeri_token_channel.sv | 94 +++++++++
 rtl/tt_um_jleugeri_token_aggregator.sv | 65 ++++++
 tb/tb_tt_um_jleugeri_token_aggregator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_um_jleugeri_tokens_pkg.sv
// Shared definitions for the token aggregator.
// - Default widths used by the aggregator, its channel and its bus interface.
// - The encoding of cfg_sel (which weight bank a write targets).
// - A signed saturation helper used for both the output clamp and the
//   residual clamp.
package tt_um_jleugeri_tokens_pkg;

    localparam int DEF_N_SOURCES       = 4;
    localparam int DEF_NEW_TOKENS_BITS = 4;
    localparam int DEF_ACC_BITS        = 8;

    // Working width of sat_signed. Callers size-cast their operands in and
    // out of it.
    localparam int SAT_W = 32;

    typedef enum logic {
        SEL_GOOD = 1'b0,
        SEL_BAD  = 1'b1
    } cfg_sel_e;

    // Clamp a signed value into the range of a 'width'-bit two's-complement
    // number: [-2^(width-1), 2^(width-1)-1].
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/tt_um_jleugeri_token_aggregator_if.sv
// Bus between the source/config side and the token aggregator.
// Signals:
//   src_token_start[N]  one-cycle start pulse per source
//   src_token_end[N]    one-cycle end pulse per source
//   cfg_we              write strobe for a weight
//   cfg_sel             weight bank: 0 = good, 1 = bad
//   cfg_addr            index of the source whose weight is written
//   cfg_data            signed weight value
//   new_good_tokens     signed good-token delta sent to the core
//   new_bad_tokens      signed bad-token delta sent to the core
//   busy                at least one residual is nonzero
//   overflow            sticky flag: a residual was clamped
// Modports:
//   master  drives the pulses and config, and receives the results
//   slave   the aggregator
interface tt_um_jleugeri_token_aggregator_if #(
    parameter int N_SOURCES       = 4,
    parameter int NEW_TOKENS_BITS = 4
);
    localparam int ADDR_W = $clog2(N_SOURCES);

    logic [N_SOURCES-1:0]              src_token_start;
    logic [N_SOURCES-1:0]              src_token_end;
    logic                              cfg_we;
    logic                              cfg_sel;
    logic [ADDR_W-1:0]                 cfg_addr;
    logic signed [NEW_TOKENS_BITS-1:0] cfg_data;
    logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens;
    logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens;
    logic                              busy;
    logic                              overflow;

    modport master (
        output src_token_start, src_token_end, cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  new_good_tokens, new_bad_tokens, busy, overflow
    );

    modport slave (
        input  src_token_start, src_token_end, cfg_we, cfg_sel, cfg_addr, cfg_data,
        output new_good_tokens, new_bad_tokens, busy, overflow
    );

endinterface

// File: rtl/tt_um_jleugeri_token_channel.sv
// One token channel (good or bad). The channel holds these parts:
// - N signed weights.
// - The weighted sum of start/end pulses.
// - A residual carry register.
// The channel saturates the output delta and carries the excess into the
// residual. The residual drains over later cycles.
// Ports:
//   clock_fast, reset   clock and synchronous active-high reset
//   src_start/src_end   per-source pulses
//   we/addr/data        weight write for this channel
//   tokens              registered saturated delta
//   busy                registered: residual nonzero
//   overflow            sticky: residual was clamped
module tt_um_jleugeri_token_channel
    import tt_um_jleugeri_tokens_pkg::*;
#(
    parameter int N_SOURCES       = DEF_N_SOURCES,
    parameter int NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
    parameter int ACC_BITS        = DEF_ACC_BITS
) (
    input  logic                              clock_fast,
    input  logic                              reset,
    input  logic [N_SOURCES-1:0]              src_start,
    input  logic [N_SOURCES-1:0]              src_end,
    input  logic                              we,
    input  logic [$clog2(N_SOURCES)-1:0]      addr,
    input  logic signed [NEW_TOKENS_BITS-1:0] data,
    output logic signed [NEW_TOKENS_BITS-1:0] tokens,
    output logic                              busy,
    output logic                              overflow
);
    // Two guard bits above the residual width. They hold residual + N*weight
    // without wrapping.
    localparam int SW = ACC_BITS + 2;

    logic signed [NEW_TOKENS_BITS-1:0] weight_q [N_SOURCES];
    logic signed [NEW_TOKENS_BITS-1:0] weight_d [N_SOURCES];
    logic signed [ACC_BITS-1:0]        residual_q, residual_d;
    logic signed [NEW_TOKENS_BITS-1:0] tokens_q, tokens_d;
    logic                              busy_q, busy_d;
    logic                              overflow_q, overflow_d;

    logic signed [SW-1:0] delta;
    logic signed [SW-1:0] total;
    logic signed [SW-1:0] remainder;

    always_comb begin
        weight_d = weight_q;
        if (we && (int'(addr) < N_SOURCES)) begin
            weight_d[addr] = data;
        end

        // A source with start and end in the same cycle contributes 0. The
        // sum reads weight_q, so a write in this cycle takes effect next cycle.
        delta = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (src_start[i] && !src_end[i]) begin
                delta = delta + SW'(weight_q[i]);
            end else if (src_end[i] && !src_start[i]) begin
                delta = delta - SW'(weight_q[i]);
            end
        end

        total      = SW'(residual_q) + delta;
        tokens_d   = NEW_TOKENS_BITS'(sat_signed(SAT_W'(total), NEW_TOKENS_BITS));
        remainder  = total - SW'(tokens_d);
        residual_d = ACC_BITS'(sat_signed(SAT_W'(remainder), ACC_BITS));
        overflow_d = overflow_q || (SW'(residual_d) != remainder);
        busy_d     = (residual_d != '0);
    end

    always_ff @(posedge clock_fast) begin
        if (reset) begin
            for (int i = 0; i < N_SOURCES; i++) begin
                weight_q[i] <= '0;
            end
            residual_q <= '0;
            tokens_q   <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            weight_q   <= weight_d;
            residual_q <= residual_d;
            tokens_q   <= tokens_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign tokens   = tokens_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/tt_um_jleugeri_token_aggregator.sv
// Token aggregator that feeds one event-processor core.
// - Collects start/end pulses from N_SOURCES sources.
// - Weights each pulse with a per-source good weight and a per-source bad
//   weight.
// - Emits registered signed good/bad deltas with one cycle of latency.
// - Carries any excess that does not fit the output range into later cycles.
// Ports:
//   clock_fast, reset   clock and synchronous active-high reset
//   bus (slave)         pulses, weight config, deltas, busy, overflow
module tt_um_jleugeri_token_aggregator
    import tt_um_jleugeri_tokens_pkg::*;
#(
    parameter int N_SOURCES       = DEF_N_SOURCES,
    parameter int NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
    parameter int ACC_BITS        = DEF_ACC_BITS
) (
    input logic                              clock_fast,
    input logic                              reset,
    tt_um_jleugeri_token_aggregator_if.slave bus
);
    logic we_good, we_bad;
    logic busy_good, busy_bad;
    logic overflow_good, overflow_bad;

    assign we_good = bus.cfg_we && (cfg_sel_e'(bus.cfg_sel) == SEL_GOOD);
    assign we_bad  = bus.cfg_we && (cfg_sel_e'(bus.cfg_sel) == SEL_BAD);

    tt_um_jleugeri_token_channel #(
        .N_SOURCES      (N_SOURCES),
        .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
        .ACC_BITS       (ACC_BITS)
    ) u_good (
        .clock_fast(clock_fast),
        .reset     (reset),
        .src_start (bus.src_token_start),
        .src_end   (bus.src_token_end),
        .we        (we_good),
        .addr      (bus.cfg_addr),
        .data      (bus.cfg_data),
        .tokens    (bus.new_good_tokens),
        .busy      (busy_good),
        .overflow  (overflow_good)
    );

    tt_um_jleugeri_token_channel #(
        .N_SOURCES      (N_SOURCES),
        .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
        .ACC_BITS       (ACC_BITS)
    ) u_bad (
        .clock_fast(clock_fast),
        .reset     (reset),
        .src_start (bus.src_token_start),
        .src_end   (bus.src_token_end),
        .we        (we_bad),
        .addr      (bus.cfg_addr),
        .data      (bus.cfg_data),
        .tokens    (bus.new_bad_tokens),
        .busy      (busy_bad),
        .overflow  (overflow_bad)
    );

    assign bus.busy     = busy_good || busy_bad;
    assign bus.overflow = overflow_good || overflow_bad;

endmodule

// File: tb/tb_tt_um_jleugeri_token_aggregator.sv
// Bench for the token aggregator.
// - Each cycle the stimulus task drives the inputs on the negedge.
// - The task then advances an integer reference model and queues the
//   expected outputs.
// - It pops the queue and compares the outputs 1 ns after the posedge.
module tb_tt_um_jleugeri_token_aggregator;
    import tt_um_jleugeri_tokens_pkg::*;

    localparam int N   = 4;
    localparam int NTB = 4;
    localparam int ACC = 8;

    logic clock_fast = 1'b0;
    logic reset      = 1'b1;

    always #5 clock_fast = ~clock_fast;

    tt_um_jleugeri_token_aggregator_if #(.N_SOURCES(N), .NEW_TOKENS_BITS(NTB)) bus ();

    tt_um_jleugeri_token_aggregator #(
        .N_SOURCES      (N),
        .NEW_TOKENS_BITS(NTB),
        .ACC_BITS       (ACC)
    ) dut (
        .clock_fast(clock_fast),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        int good;
        int bad;
        int busy;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: m_w[0] = good bank, m_w[1] = bad bank.
    int m_w   [2][N];
    int m_res [2];
    int m_ovf;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int bits);
        int hi;
        int lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic cycle(input logic [N-1:0] st, input logic [N-1:0] en,
                         input logic we, input logic sel, input int addr,
                         input int data, input logic rst);
        exp_t e;
        int   outs [2];
        @(negedge clock_fast);
        reset               = rst;
        bus.src_token_start = st;
        bus.src_token_end   = en;
        bus.cfg_we          = we;
        bus.cfg_sel         = sel;
        bus.cfg_addr        = 2'(addr);
        bus.cfg_data        = NTB'(data);

        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_res[c] = 0;
                outs[c]  = 0;
                for (int i = 0; i < N; i++) m_w[c][i] = 0;
            end
            m_ovf = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                int delta;
                int total;
                int r;
                int rc;
                delta = 0;
                for (int i = 0; i < N; i++) begin
                    if (st[i]) delta += m_w[c][i];
                    if (en[i]) delta -= m_w[c][i];
                end
                total   = m_res[c] + delta;
                outs[c] = clamp(total, NTB);
                r       = total - outs[c];
                rc      = clamp(r, ACC);
                if (rc != r) m_ovf = 1;
                m_res[c] = rc;
            end
            if (we) m_w[sel ? 1 : 0][addr] = clamp(data, NTB);
        end
        e.good = outs[0];
        e.bad  = outs[1];
        e.busy = (m_res[0] != 0 || m_res[1] != 0) ? 1 : 0;
        e.ovf  = m_ovf;
        sb.push_back(e);

        @(posedge clock_fast);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("new_good_tokens", int'(bus.new_good_tokens), e.good);
            check_eq("new_bad_tokens", int'(bus.new_bad_tokens), e.bad);
            check_eq("busy", int'(bus.busy), e.busy);
            check_eq("overflow", int'(bus.overflow), e.ovf);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic pulse(input logic [N-1:0] st, input logic [N-1:0] en);
        cycle(st, en, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic cfg(input logic sel, input int addr, input int data);
        cycle('0, '0, 1'b1, sel, addr, data, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        bus.src_token_start = '0;
        bus.src_token_end   = '0;
        bus.cfg_we          = 1'b0;
        bus.cfg_sel         = 1'b0;
        bus.cfg_addr        = '0;
        bus.cfg_data        = '0;

        // Reset and idle; pulses with zero weights.
        do_reset(3);
        idle(5);
        pulse(4'b1111, 4'b0000);
        idle(2);

        // Single weight of 3 on source 0.
        cfg(SEL_GOOD, 0, 3);
        pulse(4'b0001, 4'b0000);
        check_eq("good3_direct", int'(bus.new_good_tokens), 3);
        idle(2);

        // All good weights 7: 28 drains as 7 per cycle over four cycles.
        for (int i = 0; i < N; i++) cfg(SEL_GOOD, i, 7);
        pulse(4'b1111, 4'b0000);
        check_eq("drain_busy_direct", int'(bus.busy), 1);
        idle(5);

        // Inhibitory bad weight -8 on source 1.
        cfg(SEL_BAD, 1, -8);
        pulse(4'b0010, 4'b0000);
        check_eq("bad_neg8_direct", int'(bus.new_bad_tokens), -8);
        idle(2);
        pulse(4'b0000, 4'b0010);
        check_eq("bad_end_sat_direct", int'(bus.new_bad_tokens), 7);
        idle(3);

        // A weight write in the same cycle as the event; start and end together.
        cfg(SEL_GOOD, 2, 2);
        cycle(4'b0100, 4'b0000, 1'b1, SEL_GOOD, 2, 5, 1'b0);
        check_eq("old_weight_direct", int'(bus.new_good_tokens), 2);
        pulse(4'b0100, 4'b0000);
        check_eq("new_weight_direct", int'(bus.new_good_tokens), 5);
        pulse(4'b0100, 4'b0100);
        idle(2);

        // Continuous saturation that clamps the residual and sets overflow.
        cfg(SEL_GOOD, 2, 7);
        for (int i = 0; i < 6; i++) pulse(4'b1111, 4'b0000);
        check_eq("no_ovf_at_6", int'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) pulse(4'b1111, 4'b0000);
        check_eq("ovf_set_direct", int'(bus.overflow), 1);
        idle(3);
        do_reset(1);
        check_eq("ovf_clr_direct", int'(bus.overflow), 0);
        check_eq("busy_clr_direct", int'(bus.busy), 0);
        idle(3);

        // Random pulses and weight writes.
        for (int i = 0; i < 60; i++) begin
            cycle(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, 15)) - 8, 1'b0);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
